// File: rtl/duty_slew_ctrl.sv
// Slew-limited duty feeder for the 11-bit PWM stage; duty moves only on PWM period boundaries.
// Optional: define ZERO_CROSS_HOLD_EN to park duty at DUTY_MID for one period when a ramp crosses it.
module duty_slew_ctrl #(
    parameter int unsigned PERIOD_CYCLES = 2048,
    parameter int unsigned MAX_STEP      = 16,
    parameter logic [10:0] DUTY_MID      = 11'h400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] spd,
    input  logic        spd_vld,
    input  logic        enable,
    output logic [10:0] duty,
    output logic        duty_upd,
    output logic        at_target,
    output logic        sat
);

    localparam int unsigned     CNT_W    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [11:0]     STEP     = 12'(MAX_STEP);
    localparam logic [11:0]     MID_EXT  = {1'b0, DUTY_MID};

`ifdef ZERO_CROSS_HOLD_EN
    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DN, HOLD_MID} state_t;
`else
    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DN} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        duty_q, duty_d;
    logic [10:0]        tgt_q, tgt_d;
    logic               sat_q, sat_d;
    logic               en_q;
    logic               upd_q, upd_d;

    logic               boundary;
    logic signed [12:0] raw;
    logic [10:0]        eff_tgt;
    logic [11:0]        duty_ext, tgt_ext;
    logic [11:0]        up_gap, dn_gap, up_val, dn_val;
    logic               go_up, go_dn;

    assign boundary = (cnt_q == CNT_LAST);
    assign cnt_d    = boundary ? '0 : cnt_q + 1'b1;

    // Requests are clamped into the duty range; sat records whether clamping was needed.
    assign raw = $signed({2'b00, DUTY_MID}) + $signed({spd[11], spd});

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tgt_d = tgt_q;
        sat_d = sat_q;
        if (spd_vld && enable) begin
            if (raw < 13'sd0) begin
                tgt_d = 11'h000;
                sat_d = 1'b1;
            end else if (raw > 13'sd2047) begin
                tgt_d = 11'h7FF;
                sat_d = 1'b1;
            end else begin
                tgt_d = raw[10:0];
                sat_d = 1'b0;
            end
        end
    end

    // Effective target comes only from registers, so a same-cycle request or enable change waits a boundary.
    assign eff_tgt   = en_q ? tgt_q : DUTY_MID;
    assign at_target = (duty_q == eff_tgt);

    assign duty_ext = {1'b0, duty_q};
    assign tgt_ext  = {1'b0, eff_tgt};
    assign go_up    = (eff_tgt > duty_q);
    assign go_dn    = (eff_tgt < duty_q);
    assign up_gap   = tgt_ext - duty_ext;
    assign dn_gap   = duty_ext - tgt_ext;
    assign up_val   = duty_ext + ((up_gap > STEP) ? STEP : up_gap);
    assign dn_val   = duty_ext - ((dn_gap > STEP) ? STEP : dn_gap);

`ifdef ZERO_CROSS_HOLD_EN
    logic cross;
    assign cross = (go_up && (duty_ext < MID_EXT) && (up_val > MID_EXT)) ||
                   (go_dn && (duty_ext > MID_EXT) && (dn_val < MID_EXT));
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (boundary) begin
            case (state_q)
`ifdef ZERO_CROSS_HOLD_EN
                HOLD_MID: state_d = go_up ? RAMP_UP : (go_dn ? RAMP_DN : HOLD);
`endif
                // HOLD and both ramps step toward the current target, which also covers reversal.
                default: begin
                    if (go_up) begin
                        duty_d  = up_val[10:0];
                        state_d = (up_val == tgt_ext) ? HOLD : RAMP_UP;
                    end else if (go_dn) begin
                        duty_d  = dn_val[10:0];
                        state_d = (dn_val == tgt_ext) ? HOLD : RAMP_DN;
                    end else begin
                        state_d = HOLD;
                    end
`ifdef ZERO_CROSS_HOLD_EN
                    if (cross) begin
                        duty_d  = DUTY_MID;
                        state_d = HOLD_MID;
                    end
`endif
                end
            endcase
        end
    end

    assign upd_d = boundary && (duty_d != duty_q);

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= HOLD;
            duty_q  <= DUTY_MID;
            tgt_q   <= DUTY_MID;
            sat_q   <= 1'b0;
            en_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            sat_q   <= sat_d;
            en_q    <= enable;
            upd_q   <= upd_d;
        end
    end

    assign duty     = duty_q;
    assign duty_upd = upd_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Directed bench for duty_slew_ctrl; a short PWM period keeps the long ramps cheap.
// Inputs change and outputs are sampled on the falling edge; pe tracks the free-running period count.
module tb_duty_slew_ctrl;

    localparam int P = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] spd;
    logic        spd_vld;
    logic        enable;
    logic [10:0] duty;
    logic        duty_upd;
    logic        at_target;
    logic        sat;

    int n_vec = 0;
    int n_err = 0;
    int pe;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) pe <= 0;
        else     pe <= (pe + 1) % P;
    end

    duty_slew_ctrl #(.PERIOD_CYCLES(P), .MAX_STEP(16), .DUTY_MID(11'h400)) dut (
        .clk      (clk),
        .rst      (rst),
        .spd      (spd),
        .spd_vld  (spd_vld),
        .enable   (enable),
        .duty     (duty),
        .duty_upd (duty_upd),
        .at_target(at_target),
        .sat      (sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic goto_cnt(input int c);
        for (int n = 0; n < 2 * P && pe != c; n++) tick();
        check("goto_cnt", pe, c);
    endtask

    // Steps across one boundary: no pulse before, new duty and pulse after, pulse gone next cycle.
    task automatic boundary(input string tag, input logic [10:0] exp_duty, input logic exp_upd);
        goto_cnt(P - 1);
        check({tag, "/pre_upd"}, duty_upd, 1'b0);
        tick();
        check({tag, "/duty"}, duty, exp_duty);
        check({tag, "/upd"}, duty_upd, exp_upd);
        tick();
        check({tag, "/upd_clr"}, duty_upd, 1'b0);
    endtask

    task automatic send(input logic [11:0] v);
        spd     = v;
        spd_vld = 1'b1;
        tick();
        spd_vld = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_d;
        rst     = 1'b1;
        spd     = 12'h000;
        spd_vld = 1'b0;
        enable  = 1'b0;
        tick();
        tick();
        check("rst/duty", duty, 11'h400);
        check("rst/upd", duty_upd, 1'b0);
        check("rst/at", at_target, 1'b1);
        check("rst/sat", sat, 1'b0);
        rst    = 1'b0;
        enable = 1'b1;
        tick();

        send(12'h000);
        check("zero/sat", sat, 1'b0);
        check("zero/at", at_target, 1'b1);
        boundary("zero", 11'h400, 1'b0);

        send(12'd64);
        check("p64/sat", sat, 1'b0);
        check("p64/at_drop", at_target, 1'b0);
        boundary("p64_1", 11'h410, 1'b1);
        boundary("p64_2", 11'h420, 1'b1);
        boundary("p64_3", 11'h430, 1'b1);
        check("p64/at_mid", at_target, 1'b0);
        boundary("p64_4", 11'h440, 1'b1);
        check("p64/at_done", at_target, 1'b1);
        boundary("p64_hold", 11'h440, 1'b0);

        enable = 1'b0;
        tick();
        check("dis/at", at_target, 1'b0);
        boundary("dis_1", 11'h430, 1'b1);
        boundary("dis_2", 11'h420, 1'b1);
        boundary("dis_3", 11'h410, 1'b1);
        boundary("dis_4", 11'h400, 1'b1);
        send(12'h100);
        check("dis/vld_sat", sat, 1'b0);
        check("dis/vld_at", at_target, 1'b1);
        boundary("dis_hold", 11'h400, 1'b0);
        enable = 1'b1;
        tick();
        check("ren/at", at_target, 1'b0);
        boundary("ren_1", 11'h410, 1'b1);
        boundary("ren_2", 11'h420, 1'b1);
        boundary("ren_3", 11'h430, 1'b1);
        boundary("ren_4", 11'h440, 1'b1);

        // Request lands in the boundary cycle: that boundary still sees target 0x440.
        goto_cnt(P - 1);
        send(12'h080);
        check("simul/duty", duty, 11'h440);
        check("simul/upd", duty_upd, 1'b0);
        boundary("simul_next", 11'h450, 1'b1);

        send(12'h020);
        boundary("rev_1", 11'h440, 1'b1);
        boundary("rev_2", 11'h430, 1'b1);
        boundary("rev_3", 11'h420, 1'b1);
        boundary("rev_hold", 11'h420, 1'b0);

        send(12'h7FF);
        check("satp/sat", sat, 1'b1);
        exp_d = 11'h420;
        for (int i = 0; i < 62; i++) begin
            exp_d = (11'h7FF - exp_d > 11'd16) ? exp_d + 11'd16 : 11'h7FF;
            boundary("satp_ramp", exp_d, 1'b1);
        end
        boundary("satp_hold", 11'h7FF, 1'b0);
        check("satp/at", at_target, 1'b1);

        send(12'h800);
        check("satn/sat", sat, 1'b1);
        boundary("satn_1", 11'h7EF, 1'b1);
        boundary("satn_2", 11'h7DF, 1'b1);
        send(12'h3FF);
        check("edge_hi/sat", sat, 1'b0);
        send(12'hC00);
        check("edge_lo/sat", sat, 1'b0);
        send(12'hBFF);
        check("under/sat", sat, 1'b1);
        boundary("satn_3", 11'h7CF, 1'b1);

        goto_cnt(10);
        rst = 1'b1;
        #1;
        check("mid_rst/duty", duty, 11'h400);
        check("mid_rst/at", at_target, 1'b1);
        check("mid_rst/sat", sat, 1'b0);
        check("mid_rst/upd", duty_upd, 1'b0);
        tick();
        rst = 1'b0;

        // Counter restarts at 0 on release, so this first boundary is P cycles out.
        send(12'h008);
        check("p8/sat", sat, 1'b0);
        boundary("p8", 11'h408, 1'b1);

        send(12'hFC0);
        check("m64/sat", sat, 1'b0);
        check("m64/at", at_target, 1'b0);
`ifdef ZERO_CROSS_HOLD_EN
        boundary("zc_mid", 11'h400, 1'b1);
        boundary("zc_dwell", 11'h400, 1'b0);
        boundary("zc_1", 11'h3F0, 1'b1);
        boundary("zc_2", 11'h3E0, 1'b1);
        boundary("zc_3", 11'h3D0, 1'b1);
        boundary("zc_4", 11'h3C0, 1'b1);
        boundary("zc_hold", 11'h3C0, 1'b0);
`else
        boundary("thru_1", 11'h3F8, 1'b1);
        boundary("thru_2", 11'h3E8, 1'b1);
        boundary("thru_3", 11'h3D8, 1'b1);
        boundary("thru_4", 11'h3C8, 1'b1);
        boundary("thru_5", 11'h3C0, 1'b1);
        boundary("thru_hold", 11'h3C0, 1'b0);
`endif
        check("m64/at_done", at_target, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/duty_slew_ctrl.md
Name: duty_slew_ctrl

Overview:
- Upstream feeder for the 11-bit PWM generator.
- Converts a signed 12-bit speed request into an 11-bit duty value centred on mid-scale.
- Limits the duty change rate to MAX_STEP counts per PWM period.
- Applies duty updates only on PWM period boundaries, so the PWM stage never sees a mid-period duty change.

Parameters:
- PERIOD_CYCLES, 2048: clocks per PWM period; matches the free-running 11-bit PWM counter.
- MAX_STEP, 16: maximum duty change per period, in duty counts (1..1023).
- DUTY_MID, 11'h400: duty for zero speed (50%, no net drive).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spd  in  12  signed speed request (two's complement)
- spd_vld  in  1  one-cycle strobe; capture spd
- enable  in  1  drive enable; low forces target to DUTY_MID
- duty  out  11  slew-limited duty to the PWM stage
- duty_upd  out  1  one-cycle pulse in the cycle a new duty value appears
- at_target  out  1  high when duty equals the current target
- sat  out  1  high when the last captured request was clamped

Behaviour:
- Reset (async, rst=1): duty=DUTY_MID, target=DUTY_MID, period counter=0, state=HOLD, duty_upd=0, at_target=1, sat=0.
- Target capture:
  - On spd_vld, compute raw = DUTY_MID + sign-extended spd in 13-bit signed arithmetic.
  - Clamp raw to 0..2047; target and sat are registered the next cycle (1-cycle latency).
  - sat=1 iff clamping occurred; sat holds until the next spd_vld.
  - spd_vld is ignored while enable=0, but the effective target is then DUTY_MID; the captured target is retained and reapplied when enable returns to 1.
- Period counter:
  - Counts 0..PERIOD_CYCLES-1 and wraps.
  - Boundary cycle is count==PERIOD_CYCLES-1.
  - Free-running from reset, so it aligns with a PWM counter released from the same reset.
- State machine, evaluated only in the boundary cycle using the registered effective target:
  - HOLD: if target>duty go to RAMP_UP; if target<duty go to RAMP_DN; else stay.
  - RAMP_UP: duty += min(MAX_STEP, target-duty); go to HOLD when result==target.
  - RAMP_DN: duty -= min(MAX_STEP, duty-target); go to HOLD when result==target.
  - Target reversal mid-ramp (e.g. RAMP_UP with target now below duty): switch directly to RAMP_DN at that boundary and step down in the same boundary.
- Output timing:
  - The new duty is visible the cycle after the boundary cycle.
  - duty_upd pulses in that same cycle, only if duty actually changed.
  - No duty change ever occurs outside this cycle.
- at_target: combinational compare of registered duty and effective target. It may drop the cycle after spd_vld, before any duty change.
- Simultaneous events:
  - spd_vld or an enable change in the boundary cycle: the boundary uses the old target; the new target takes effect at the next boundary.
- Width rule: step arithmetic uses 12-bit unsigned intermediates; duty never wraps past 0 or 2047.
- Reset mid-ramp: duty returns to DUTY_MID immediately (async), and the period counter restarts at 0.

Optional Feature:
- Macro: ZERO_CROSS_HOLD_EN.
- With it defined:
  - When a ramp step would carry duty across DUTY_MID (strictly from one side to the other), duty is set to exactly DUTY_MID at that boundary.
  - State becomes HOLD_MID for one full period.
  - The ramp then resumes toward the target at the following boundary.
  - duty_upd pulses for the step to DUTY_MID and not during the dwell.
- Without it: HOLD_MID does not exist and ramps pass through DUTY_MID like any other value.

Test Plan:
- Reset, then spd=12'h000 with spd_vld and enable=1 -> duty stays 11'h400, duty_upd never pulses, at_target=1, sat=0.
- spd=+64 with spd_vld -> target 0x440. Duty reaches 0x410, 0x420, 0x430, 0x440 on four consecutive boundaries (each 1 cycle after count 2047); at_target=1 after the 4th; each duty_upd pulse is exactly 1 cycle.
- spd=12'h7FF (+2047) -> sat=1, target 0x7FF; after 64 periods duty=0x7FF and never exceeds it. Then spd=12'h800 (-2048) -> sat=1, target 0x000, and duty ramps down by 16 per period.
- At duty=0x440, deassert enable -> target DUTY_MID; duty steps 0x430, 0x420, 0x410, 0x400. spd_vld pulses with enable low do not move duty. Reasserting enable resumes ramping toward the retained target 0x440.
- spd_vld asserted in the boundary cycle (count 2047) -> that boundary steps toward the old target; the new target is applied only at the following boundary.
- ZERO_CROSS_HOLD_EN defined, duty=0x408, spd=-64 -> duty=0x400 at boundary 1, unchanged at boundary 2 (no duty_upd), 0x3F0 at boundary 3, then 0x3E0, 0x3D0, 0x3C0 -> HOLD.
